// File: rtl/fp_mul_arbiter_if.sv
// fp_mul_arbiter_if
//   Request/response bundle shared between N_REQ requesters, the arbiter
//   and the response consumer.
//   slave  modport : arbiter side (accepts requests, produces responses)
//   master modport : requester/consumer side
//   req_valid/req_ready : per-requester handshake, one bit each
//   req_x/req_y         : 32-bit operand slices, requester i at [32i+31:32i]
//   req_rmode           : 3-bit rounding mode slices, requester i at [3i+2:3i]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_z        : requester tag and product
//   rsp_ovrf/rsp_udrf   : exception flags of this product
interface fp_mul_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) ();
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*32-1:0] req_x;
  logic [N_REQ*32-1:0] req_y;
  logic [N_REQ*3-1:0]  req_rmode;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [31:0]         rsp_z;
  logic                rsp_ovrf;
  logic                rsp_udrf;

  modport slave (
    input  req_valid, req_x, req_y, req_rmode, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_z, rsp_ovrf, rsp_udrf
  );

  modport master (
    output req_valid, req_x, req_y, req_rmode, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_z, rsp_ovrf, rsp_udrf
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter
//   Round-robin arbiter feeding one shared combinational fp_mul through a
//   registered issue stage (S1) and capturing its output in a response
//   register (S2) tagged with the requester index.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : request/response handshakes, see fp_mul_arbiter_if
//   mul_x/mul_y       : registered operands to fp_mul
//   mul_rmode         : registered (sanitised) rounding mode to fp_mul
//   mul_z             : product from fp_mul
//   mul_ovrf/mul_udrf : exception flags from fp_mul
//   flags_sticky      : {bad_rmode, udrf, ovrf}, accumulated until flags_clr
//   flags_clr         : synchronous clear; a same-cycle set event survives
module fp_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fp_mul_arbiter_if.slave        bus,
  output logic [31:0]            mul_x,
  output logic [31:0]            mul_y,
  output logic [2:0]             mul_rmode,
  input  logic [31:0]            mul_z,
  input  logic                   mul_ovrf,
  input  logic                   mul_udrf,
  output logic [2:0]             flags_sticky,
  input  logic                   flags_clr
);

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  ptr_next;
  logic [ID_W-1:0]  grant;
  logic             grant_v;
  int               arb_idx;

  logic             s1_v;
  logic [ID_W-1:0]  s1_id;
  logic             s1_adv;
  logic             s1_load_ok;
  logic             accept;

  logic [31:0]      g_x;
  logic [31:0]      g_y;
  logic [2:0]       g_rmode;
  logic             g_bad;

  logic             rsp_valid_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [31:0]      rsp_z_q;
  logic             rsp_ovrf_q;
  logic             rsp_udrf_q;

  logic [2:0]       flag_set;

  // ---------------------------------------------------------------------
  // Pipeline control. S1 moves into S2 when S2 is empty or being drained
  // in the same cycle; S1 can take a new request when it is empty or its
  // current content is leaving.
  // ---------------------------------------------------------------------
  assign s1_adv     = s1_v & (~rsp_valid_q | bus.rsp_ready);
  assign s1_load_ok = ~s1_v | s1_adv;
  assign accept     = grant_v & s1_load_ok;

  // ---------------------------------------------------------------------
  // Round-robin search starting at ptr, wrapping modulo N_REQ. N_REQ need
  // not be a power of two, so the wrap is an explicit subtraction.
  // ---------------------------------------------------------------------
  always_comb begin
    grant   = '0;
    grant_v = 1'b0;
    arb_idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      arb_idx = int'(ptr) + k;
      if (arb_idx >= N_REQ) arb_idx = arb_idx - N_REQ;
      if (!grant_v && bus.req_valid[arb_idx]) begin
        grant_v = 1'b1;
        grant   = ID_W'(arb_idx);
      end
    end
  end

  assign ptr_next = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;

  // req_ready is gated by rst_n so nothing looks accepted while in reset.
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && grant_v && s1_load_ok) bus.req_ready = N_REQ'(1) << grant;
  end

  // Select the granted requester's operand slices.
  always_comb begin
    g_x     = '0;
    g_y     = '0;
    g_rmode = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        g_x     = bus.req_x[32*i +: 32];
        g_y     = bus.req_y[32*i +: 32];
        g_rmode = bus.req_rmode[3*i +: 3];
      end
    end
  end

  // Rounding modes above 3'b100 are undefined for fp_mul.
  assign g_bad = (g_rmode > 3'b100);

  // ---------------------------------------------------------------------
  // Arbitration pointer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= ptr_next;
    end
  end

  // ---------------------------------------------------------------------
  // S1 issue register. Operands hold when S1 empties so fp_mul inputs do
  // not toggle needlessly.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_id     <= '0;
      mul_x     <= '0;
      mul_y     <= '0;
      mul_rmode <= '0;
    end else begin
      if (s1_load_ok) s1_v <= accept;
      if (accept) begin
        s1_id     <= grant;
        mul_x     <= g_x;
        mul_y     <= g_y;
        mul_rmode <= g_bad ? 3'b000 : g_rmode;
      end
    end
  end

  // ---------------------------------------------------------------------
  // S2 response register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_z_q     <= '0;
      rsp_ovrf_q  <= 1'b0;
      rsp_udrf_q  <= 1'b0;
    end else if (s1_adv) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= s1_id;
      rsp_z_q     <= mul_z;
      rsp_ovrf_q  <= mul_ovrf;
      rsp_udrf_q  <= mul_udrf;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.rsp_ovrf  = rsp_ovrf_q;
  assign bus.rsp_udrf  = rsp_udrf_q;

  // ---------------------------------------------------------------------
  // Sticky flags: clear first, then OR in this cycle's events.
  // ---------------------------------------------------------------------
  assign flag_set = {accept & g_bad, s1_adv & mul_udrf, s1_adv & mul_ovrf};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_sticky <= '0;
    end else begin
      flags_sticky <= (flags_clr ? 3'b000 : flags_sticky) | flag_set;
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
module tb_fp_mul_arbiter;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mul_x, mul_y, mul_z;
  logic [2:0]  mul_rmode;
  logic        mul_ovrf, mul_udrf;
  logic [2:0]  flags_sticky;
  logic        flags_clr;

  always #5 clk = ~clk;

  fp_mul_arbiter_if #(.N_REQ(N)) bus ();

  fp_mul_arbiter #(.N_REQ(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .mul_x        (mul_x),
    .mul_y        (mul_y),
    .mul_rmode    (mul_rmode),
    .mul_z        (mul_z),
    .mul_ovrf     (mul_ovrf),
    .mul_udrf     (mul_udrf),
    .flags_sticky (flags_sticky),
    .flags_clr    (flags_clr)
  );

  // Simplified fp_mul: normal operands, truncating; returns {ovrf, udrf, z}.
  function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] p;
    logic [22:0] man;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {2'b00, s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e++;
      man = p[46:24];
    end else begin
      man = p[45:23];
    end
    if (e >= 255) return {2'b10, s, 8'hff, 23'd0};
    if (e <= 0)   return {2'b01, s, 31'd0};
    return {2'b00, s, e[7:0], man};
  endfunction

  assign {mul_ovrf, mul_udrf, mul_z} = fmul(mul_x, mul_y);

  typedef struct {
    logic [1:0]  id;
    logic [31:0] x, y, z;
    logic [2:0]  rm;
    logic        ov, ud;
  } ent_t;

  ent_t       q[$];
  int         acc_log[$];
  int         pop_log[$];
  int         acc_cnt;
  int         checks = 0;
  int         errors = 0;

  logic       m_s1v, m_rspv, m_adv, m_lok, eg_v;
  int         m_ptr, eg;
  logic [2:0] m_flags, m_set;
  logic [3:0] exp_rdy;
  ent_t       ne;
  logic [33:0] r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard/model: expectations pushed on accept, compared while held in
  // S2 and popped when the response handshake completes.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_s1v = 1'b0; m_rspv = 1'b0; m_ptr = 0; m_flags = 3'b000;
      q.delete();
    end else begin
      eg_v = 1'b0; eg = 0;
      for (int k = 0; k < N; k++) begin
        if (!eg_v && bus.req_valid[(m_ptr + k) % N]) begin
          eg_v = 1'b1;
          eg = (m_ptr + k) % N;
        end
      end
      m_adv = m_s1v && (!m_rspv || bus.rsp_ready);
      m_lok = !m_s1v || m_adv;
      exp_rdy = (eg_v && m_lok) ? (4'b0001 << eg) : 4'b0000;

      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rspv));
      if (m_rspv && q.size() > 0) begin
        chk("rsp_id",   32'(bus.rsp_id),   32'(q[0].id));
        chk("rsp_z",    bus.rsp_z,          q[0].z);
        chk("rsp_ovrf", 32'(bus.rsp_ovrf), 32'(q[0].ov));
        chk("rsp_udrf", 32'(bus.rsp_udrf), 32'(q[0].ud));
      end
      if (m_s1v && q.size() > 0) begin
        chk("mul_x",     mul_x,            q[$].x);
        chk("mul_y",     mul_y,            q[$].y);
        chk("mul_rmode", 32'(mul_rmode),   32'(q[$].rm));
      end
      chk("flags_sticky", 32'(flags_sticky), 32'(m_flags));

      for (int i = 0; i < N; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          acc_cnt++;
          acc_log.push_back(i);
        end

      m_set = 3'b000;
      if (m_adv && q.size() > 0) m_set[1:0] = {q[$].ud, q[$].ov};
      if (m_rspv && bus.rsp_ready) begin
        if (bus.rsp_valid) pop_log.push_back(int'(bus.rsp_id));
        if (q.size() > 0) void'(q.pop_front());
      end
      if (eg_v && m_lok) begin
        ne.id = 2'(eg);
        ne.x  = bus.req_x[32*eg +: 32];
        ne.y  = bus.req_y[32*eg +: 32];
        ne.rm = bus.req_rmode[3*eg +: 3];
        if (ne.rm > 3'b100) begin
          ne.rm = 3'b000;
          m_set[2] = 1'b1;
        end
        r = fmul(ne.x, ne.y);
        {ne.ov, ne.ud, ne.z} = r;
        q.push_back(ne);
        m_ptr = (eg + 1) % N;
      end
      m_flags = (flags_clr ? 3'b000 : m_flags) | m_set;
      m_rspv  = m_adv || (m_rspv && !bus.rsp_ready);
      m_s1v   = (eg_v && m_lok) || (m_s1v && !m_adv);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y,
                         input logic [2:0] rm);
    bus.req_x[32*i +: 32]   = x;
    bus.req_y[32*i +: 32]   = y;
    bus.req_rmode[3*i +: 3] = rm;
  endtask

  task automatic set_all();
    for (int i = 0; i < N; i++)
      set_req(i, 32'h3f800000 + 32'(i) * 32'h00100000,
              32'h40000000 + 32'(i) * 32'h00080000, 3'(i));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0; bus.req_x = '0; bus.req_y = '0; bus.req_rmode = '0;
    bus.rsp_ready = 1'b1; flags_clr = 1'b0; acc_cnt = 0;
    tick(2);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mul_x",     mul_x,              32'd0);
    chk("rst_mul_rmode", 32'(mul_rmode),     32'd0);
    chk("rst_rsp_z",     bus.rsp_z,          32'd0);
    chk("rst_flags",     32'(flags_sticky),  32'd0);
    rst_n = 1'b1;
    tick(1);

    // single request, flow-through
    set_req(2, 32'h40400000, 32'h40400000, 3'b001);
    bus.req_valid = 4'b0100;
    tick(1);
    chk("ft_mul_x",     mul_x,          32'h40400000);
    chk("ft_mul_rmode", 32'(mul_rmode), 32'd1);
    bus.req_valid = 4'b0000;
    tick(1);
    chk("ft_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("ft_rsp_z",     bus.rsp_z,          32'h41100000);
    chk("ft_rsp_id",    32'(bus.rsp_id),    32'd2);
    chk("ft_flags",     32'({bus.rsp_ovrf, bus.rsp_udrf}), 32'd0);
    tick(2);

    // round robin
    do_reset();
    acc_log.delete(); pop_log.delete();
    set_all();
    bus.req_valid = 4'hf;
    tick(8);
    bus.req_valid = 4'h0;
    tick(4);
    chk("rr_acc_count", 32'(acc_log.size()), 32'd8);
    chk("rr_rsp_count", 32'(pop_log.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < acc_log.size()) chk("rr_acc_order", 32'(acc_log[k]), 32'(k % 4));
      if (k < pop_log.size()) chk("rr_rsp_order", 32'(pop_log[k]), 32'(k % 4));
    end

    // backpressure
    bus.rsp_ready = 1'b0;
    acc_cnt = 0;
    pop_log.delete();
    bus.req_valid = 4'hf;
    tick(5);
    chk("bp_accepts",   32'(acc_cnt),        32'd2);
    chk("bp_req_ready", 32'(bus.req_ready),  32'd0);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'h0;
    tick(4);
    chk("bp_drain_count", 32'(pop_log.size()), 32'd2);
    if (pop_log.size() == 2) begin
      chk("bp_drain_0", 32'(pop_log[0]), 32'd0);
      chk("bp_drain_1", 32'(pop_log[1]), 32'd1);
    end
    chk("bp_empty", 32'(bus.rsp_valid), 32'd0);

    // flags
    do_reset();
    set_req(0, 32'h7f000000, 32'h7f000000, 3'b000);
    bus.req_valid = 4'b0001;
    tick(1);
    bus.req_valid = 4'b0000;
    tick(1);
    chk("fl_rsp_ovrf", 32'(bus.rsp_ovrf),       32'd1);
    chk("fl_sticky_o", 32'(flags_sticky[0]),    32'd1);
    tick(1);
    set_req(1, 32'h40400000, 32'h40400000, 3'b111);
    bus.req_valid = 4'b0010;
    tick(1);
    chk("fl_rmode_san", 32'(mul_rmode),       32'd0);
    chk("fl_sticky_b",  32'(flags_sticky[2]), 32'd1);
    bus.req_valid = 4'b0000;
    tick(2);
    set_req(2, 32'h7f000000, 32'h7f000000, 3'b000);
    bus.req_valid = 4'b0100;
    tick(1);
    bus.req_valid = 4'b0000;
    flags_clr = 1'b1;
    tick(1);
    flags_clr = 1'b0;
    chk("fl_clr_set", 32'(flags_sticky), 32'd1);
    tick(2);

    // reset mid-operation
    bus.rsp_ready = 1'b0;
    set_all();
    bus.req_valid = 4'hf;
    tick(3);
    chk("mr_s2_full", 32'(bus.rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_req_ready", 32'(bus.req_ready), 32'd0);
    chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mr_rsp_id",    32'(bus.rsp_id),    32'd0);
    chk("mr_rsp_z",     bus.rsp_z,          32'd0);
    chk("mr_rsp_flags", 32'({bus.rsp_ovrf, bus.rsp_udrf}), 32'd0);
    chk("mr_mul_x",     mul_x,              32'd0);
    chk("mr_mul_y",     mul_y,              32'd0);
    chk("mr_mul_rmode", 32'(mul_rmode),     32'd0);
    chk("mr_flags",     32'(flags_sticky),  32'd0);
    bus.req_valid = 4'b1010;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mr_no_stale", 32'(bus.rsp_valid), 32'd0);
    acc_log.delete(); pop_log.delete();
    tick(2);
    bus.req_valid = 4'b0000;
    tick(4);
    chk("mr_acc_count", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() > 0) chk("mr_first_grant", 32'(acc_log[0]), 32'd1);
    chk("mr_rsp_count", 32'(pop_log.size()), 32'd2);
    if (pop_log.size() == 2) begin
      chk("mr_rsp_0", 32'(pop_log[0]), 32'd1);
      chk("mr_rsp_1", 32'(pop_log[1]), 32'd3);
    end

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Round-robin arbiter and two-stage issue/response pipeline that shares one combinational single-precision multiplier (`fp_mul`) among `N_REQ` requesters. It accepts operand pairs with a rounding mode over per-requester valid/ready handshakes and drives the multiplier from a registered issue stage. It captures the result and the `ovrf`/`udrf` flags into a response register tagged with the requester index. It also keeps sticky exception flags for software.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `ID_W`, default `$clog2(N_REQ)`: width of the requester tag.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  N_REQ: request valid, one bit per requester.
- `req_ready`  out  N_REQ: request accepted on `valid & ready` at a rising edge.
- `req_x`, `req_y`  in  N_REQ*32: operands; requester i uses slice [32i+31:32i].
- `req_rmode`  in  N_REQ*3: rounding mode; requester i uses slice [3i+2:3i].
- `mul_x`, `mul_y`  out  32: operands to `fp_mul` (registered).
- `mul_rmode`  out  3: `r_mode` to `fp_mul` (registered).
- `mul_z`  in  32: `fp_Z` from `fp_mul`.
- `mul_ovrf`, `mul_udrf`  in  1: `ovrf`/`udrf` from `fp_mul`.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: response consumer ready.
- `rsp_id`  out  ID_W: index of the requester that issued the response.
- `rsp_z`  out  32: product.
- `rsp_ovrf`, `rsp_udrf`  out  1: flags of this product.
- `flags_sticky`  out  3: {bad_rmode, udrf, ovrf}, accumulated.
- `flags_clr`  in  1: synchronous clear of `flags_sticky`.

## Operation
- **Stages.** S1 is the issue register: `s1_v`, id, x, y, rmode. S2 is the response register: `rsp_*`. `fp_mul` sits combinationally between S1 and S2.
- **S1 advance.** `s1_adv = s1_v & (!rsp_valid | rsp_ready)`. When `s1_adv` is high, S2 loads `mul_z`, `mul_ovrf`, `mul_udrf` and the S1 id.
- **S1 load.** `s1_load_ok = !s1_v | s1_adv`.
- **S2 valid.** When `rsp_valid & rsp_ready & !s1_adv`, `rsp_valid` clears.
- **Arbitration.** Round-robin pointer `ptr`.
  - Grant goes to the first i with `req_valid[i]`, searching from `ptr` upward and wrapping modulo `N_REQ`.
  - `req_ready[grant] = s1_load_ok`. All other `req_ready` bits are 0.
  - At most one bit of `req_ready` is high in any cycle.
  - `req_ready` may depend combinationally on `req_valid` and `rsp_ready`.
- **Acceptance.** On accept, S1 loads the granted slices and `ptr <= grant+1` (mod `N_REQ`). With no accept, `ptr` holds.
- **Rounding-mode sanitising.** A `req_rmode` value above 3'b100 is replaced by 3'b000 in S1, and bad_rmode is set.
- **Sticky flags.** On each S2 load, ovrf |= `mul_ovrf` and udrf |= `mul_udrf`.
  - If `flags_clr` coincides with a set event in the same cycle, the result is clear-then-set: the new event is retained.
- **Operand holding.** `mul_x`/`mul_y`/`mul_rmode` hold their last values when S1 is empty. They are not zeroed on drain.
- **Reset.** All of the following go to zero: `s1_v`, `rsp_valid`, `ptr`, `mul_x`, `mul_y`, `mul_rmode`, `rsp_id`, `rsp_z`, `rsp_ovrf`, `rsp_udrf`, `flags_sticky`. `req_ready` is 0 while `rst_n` is low.
  - Assertion mid-operation discards in-flight S1 and S2 contents; no response is emitted for them.

## Timing
- **Latency.** A request accepted at edge k appears on `rsp_*` with `rsp_valid=1` after edge k+1, provided S2 was free or draining.
- **Throughput.** One result per cycle with `rsp_ready` held high.
- **Backpressure.** While `rsp_valid & !rsp_ready`, `rsp_*` stays stable. S1 holds, so `mul_*` stays stable. With S1 full, `req_ready` is all zero. At most two requests are in flight.
- **Simultaneous events.** Drain of S2, S1→S2 advance and a new S1 accept may all occur in one cycle.
- **Fairness.** A continuously requesting source waits at most `N_REQ-1` accepts of other sources.
- **Pointer wrap.** `ptr` wraps from `N_REQ-1` to 0.

## Test plan
- **Single request, flow-through.** Reset, then requester 2 sends x=0x40400000, y=0x40400000, rmode=001 with `rsp_ready=1`.
  - Response two edges after `valid` rises: `rsp_z=0x41100000`, `rsp_id=2`, flags 0.
- **Round-robin.** All 4 requesters hold `valid` with `rsp_ready=1`.
  - Accept order is 0,1,2,3,0,…, one accept per cycle.
  - `rsp_id` follows the same sequence.
- **Backpressure.** `rsp_ready=0` for 5 cycles with continuous requests.
  - Exactly 2 accepts occur, then `req_ready=0`.
  - `rsp_*` is stable throughout.
  - After `rsp_ready=1`, both responses drain in order with no loss or duplication.
- **Flags.**
  - x=0x7f000000, y=0x7f000000 gives `rsp_ovrf=1` and `flags_sticky[0]=1`.
  - `req_rmode=3'b111` gives `mul_rmode=000` and `flags_sticky[2]=1`.
  - `flags_clr` together with a new overflow result leaves `flags_sticky[0]=1`.
- **Reset mid-operation.** Assert `rst_n=0` with S1 and S2 both full.
  - All outputs read 0 and `ptr=0`.
  - No stale response appears after release.
  - The next grant goes to the lowest-index valid requester.
